// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector host sequencer.
//   MV_VECTOR_SIZE  : default matrix dimension
//   BYTE_ADDR_SHIFT : word address -> BRAM byte address shift
//   mv_state_t      : sequencer FSM states
//   load_words()    : number of words in one load (matrix + vector)
package mv_pkg;

    localparam int MV_VECTOR_SIZE  = 64;
    localparam int BYTE_ADDR_SHIFT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_READ,
        S_DRAIN
    } mv_state_t;

    function automatic int load_words(input int vs);
        return vs * vs + vs;
    endfunction

endpackage

// File: rtl/mv_skid_buf.sv
// Two-entry valid/ready buffer for 32-bit data plus a last flag.
// Absorbs the one-cycle BRAM read latency so reads can be issued at full rate
// while the output stream is back-pressured.
//   aclk, aresetn : clock, asynchronous active-low reset
//   in_data/in_last/in_valid : push side (caller guarantees space via level)
//   level     : number of occupied entries (0..2)
//   out_data/out_last/out_valid/out_ready : stream side
module mv_skid_buf (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic [1:0]  level,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
);

    // Entry layout: {last, data}
    logic [32:0] head_reg, head_next;
    logic [32:0] spare_reg, spare_next;
    logic        head_valid_reg, head_valid_next;
    logic        spare_valid_reg, spare_valid_next;
    logic        pop;

    always_comb begin
        head_next        = head_reg;
        spare_next       = spare_reg;
        head_valid_next  = head_valid_reg;
        spare_valid_next = spare_valid_reg;
        pop              = head_valid_reg && out_ready;

        if (pop) begin
            if (spare_valid_reg) begin
                head_next        = spare_reg;
                spare_valid_next = 1'b0;
            end else begin
                head_valid_next  = 1'b0;
            end
        end

        // Push lands in the head if it is (or just became) free, else in the spare.
        if (in_valid) begin
            if (!head_valid_next) begin
                head_next       = {in_last, in_data};
                head_valid_next = 1'b1;
            end else begin
                spare_next       = {in_last, in_data};
                spare_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            head_reg        <= '0;
            spare_reg       <= '0;
            head_valid_reg  <= 1'b0;
            spare_valid_reg <= 1'b0;
        end else begin
            head_reg        <= head_next;
            spare_reg       <= spare_next;
            head_valid_reg  <= head_valid_next;
            spare_valid_reg <= spare_valid_next;
        end
    end

    assign out_data  = head_reg[31:0];
    assign out_last  = head_reg[32];
    assign out_valid = head_valid_reg;
    assign level     = {1'b0, head_valid_reg} + {1'b0, spare_valid_reg};

endmodule

// File: rtl/mv_host_seq.sv
// Host-side sequencer for the matrix-vector PE controller.
// Loads VECTOR_SIZE^2 matrix words then VECTOR_SIZE vector words from the
// input stream into BRAM, pulses pe_start, waits for pe_done (with optional
// watchdog), then reads VECTOR_SIZE result words back and streams them out.
//   aclk, aresetn                       : clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready           : load stream
//   m_tdata/m_tvalid/m_tready/m_tlast   : result stream
//   pe_start/pe_done                    : PE controller handshake pulses
//   BRAM_ADDR/WRDATA/WE/EN/RDDATA       : shared BRAM port (byte addressed)
//   busy                                : high outside S_IDLE
//   err_timeout                         : sticky watchdog error
module mv_host_seq
    import mv_pkg::*;
#(
    parameter int VECTOR_SIZE  = MV_VECTOR_SIZE,
    parameter int ADDR_W       = 13,
    parameter int WAIT_TIMEOUT = 1000000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        pe_start,
    input  logic        pe_done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_EN,
    input  logic [31:0] BRAM_RDDATA,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(load_words(VECTOR_SIZE) - 1);
    localparam logic [ADDR_W-1:0] READ_LAST = ADDR_W'(VECTOR_SIZE - 1);
    localparam bit                WD_ENABLE = (WAIT_TIMEOUT > 0);
    localparam logic [31:0]       WD_LAST   = WD_ENABLE ? 32'(WAIT_TIMEOUT - 1) : 32'd0;

    mv_state_t         state_reg, state_next;
    logic [ADDR_W-1:0] wcnt_reg, wcnt_next;
    logic [ADDR_W-1:0] rcnt_reg, rcnt_next;
    logic [31:0]       wd_reg, wd_next;
    logic              err_reg, err_next;
    logic              rd_pend_reg;
    logic              rd_last_reg;

    logic [ADDR_W-1:0] word_addr;
    logic              wr_en;
    logic              rd_issue;
    logic              rd_space;
    logic              skid_pop;
    logic [1:0]        skid_level;

    // A read may be issued only if the word it returns next cycle is
    // guaranteed a slot: occupied + in-flight entries, minus a pop happening now.
    assign skid_pop = m_tvalid && m_tready;
    assign rd_space = (({1'b0, skid_level} + {2'b00, rd_pend_reg}) < 3'd2) || skid_pop;

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        rcnt_next  = rcnt_reg;
        wd_next    = wd_reg;
        err_next   = err_reg;
        s_tready   = 1'b0;
        pe_start   = 1'b0;
        wr_en      = 1'b0;
        rd_issue   = 1'b0;
        word_addr  = '0;

        case (state_reg)
            S_IDLE: begin
                // Entry only; the first word is taken in S_LOAD.
                if (s_tvalid) begin
                    state_next = S_LOAD;
                    wcnt_next  = '0;
                    err_next   = 1'b0;
                end
            end
            S_LOAD: begin
                s_tready  = 1'b1;
                wr_en     = s_tvalid;
                word_addr = wcnt_reg;
                if (s_tvalid) begin
                    if (wcnt_reg == LOAD_LAST) begin
                        state_next = S_KICK;
                        wcnt_next  = '0;
                    end else begin
                        wcnt_next  = wcnt_reg + 1'b1;
                    end
                end
            end
            S_KICK: begin
                pe_start   = 1'b1;
                wd_next    = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (pe_done) begin
                    state_next = S_READ;
                    rcnt_next  = '0;
                end else if (WD_ENABLE && (wd_reg == WD_LAST)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else if (WD_ENABLE) begin
                    wd_next    = wd_reg + 32'd1;
                end
            end
            S_READ: begin
                word_addr = rcnt_reg;
                if (rd_space) begin
                    rd_issue = 1'b1;
                    if (rcnt_reg == READ_LAST) begin
                        state_next = S_DRAIN;
                    end else begin
                        rcnt_next  = rcnt_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (skid_pop && m_tlast) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg   <= S_IDLE;
            wcnt_reg    <= '0;
            rcnt_reg    <= '0;
            wd_reg      <= '0;
            err_reg     <= 1'b0;
            rd_pend_reg <= 1'b0;
            rd_last_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wcnt_reg    <= wcnt_next;
            rcnt_reg    <= rcnt_next;
            wd_reg      <= wd_next;
            err_reg     <= err_next;
            rd_pend_reg <= rd_issue;
            rd_last_reg <= rd_issue && (rcnt_reg == READ_LAST);
        end
    end

    // BRAM port: all controls decode from the state register, so an
    // asynchronous reset forces them low immediately.
    assign BRAM_EN     = wr_en || rd_issue;
    assign BRAM_ADDR   = 32'(word_addr) << BYTE_ADDR_SHIFT;
    assign BRAM_WRDATA = wr_en ? s_tdata : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign BRAM_WE[gi] = wr_en;
        end
    endgenerate

    mv_skid_buf u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (BRAM_RDDATA),
        .in_last   (rd_last_reg),
        .in_valid  (rd_pend_reg),
        .level     (skid_level),
        .out_data  (m_tdata),
        .out_last  (m_tlast),
        .out_valid (m_tvalid),
        .out_ready (m_tready)
    );

    assign busy        = (state_reg != S_IDLE);
    assign err_timeout = err_reg;

endmodule

// File: tb/tb_mv_host_seq.sv
module tb_mv_host_seq;

    localparam int VS    = 4;
    localparam int NLOAD = VS * VS + VS;
    localparam int TO    = 50;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        pe_start;
    logic        pe_done = 1'b0;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        BRAM_EN;
    logic [31:0] BRAM_RDDATA = '0;
    logic        busy;
    logic        err_timeout;

    always #5 aclk = ~aclk;

    mv_host_seq #(
        .VECTOR_SIZE  (VS),
        .ADDR_W       (13),
        .WAIT_TIMEOUT (TO)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .pe_start    (pe_start),
        .pe_done     (pe_done),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_WRDATA (BRAM_WRDATA),
        .BRAM_WE     (BRAM_WE),
        .BRAM_EN     (BRAM_EN),
        .BRAM_RDDATA (BRAM_RDDATA),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  exp_wr_q[$];
    res_t exp_res_q[$];

    logic [31:0] mem [0:255];
    logic [31:0] res_buf [0:VS-1];
    int          load_req = 0;
    int          load_ack = 0;
    int          cyc = 0;
    int          pe_start_cnt = 0;
    int          last_start_cyc = 0;
    int          tready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int          pe_mode = 1;       // 1: answer pe_start with results + pe_done, 0: stay silent
    bit          res_fixed = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return s_tready | m_tvalid | (|m_tdata) | m_tlast | pe_start | (|BRAM_ADDR) |
               (|BRAM_WRDATA) | (|BRAM_WE) | BRAM_EN | busy | err_timeout;
    endfunction

    // BRAM model: registered read, full-word write; PE results are copied in
    // through a request/acknowledge pair so only this block writes mem.
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (load_req != load_ack) begin
            for (int k = 0; k < VS; k++) mem[k] <= res_buf[k];
            load_ack <= load_req;
        end
        if (BRAM_EN) begin
            if (BRAM_WE == 4'hF) mem[BRAM_ADDR[9:2]] <= BRAM_WRDATA;
            BRAM_RDDATA <= mem[BRAM_ADDR[9:2]];
        end
    end

    // m_tready driver
    initial begin
        int ph;
        logic [3:0] pat;
        ph  = 0;
        pat = 4'b1001;
        forever begin
            @(posedge aclk);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = pat[3 - (ph % 4)];
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    // BRAM write monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (aresetn && BRAM_EN && (BRAM_WE != 4'h0)) begin
                checks++;
                if (exp_wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL bram_write unexpected addr=%h data=%h we=%h", BRAM_ADDR, BRAM_WRDATA, BRAM_WE);
                end else begin
                    e = exp_wr_q.pop_front();
                    if (BRAM_WE !== 4'hF || BRAM_ADDR !== e.addr || BRAM_WRDATA !== e.data) begin
                        errors++;
                        $display("FAIL bram_write actual addr=%h data=%h we=%h expected addr=%h data=%h we=f",
                                 BRAM_ADDR, BRAM_WRDATA, BRAM_WE, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Result stream monitor: order, last flag, stability under back-pressure
    initial begin
        res_t        r;
        bit          stalled;
        logic [31:0] st_data;
        logic        st_last;
        stalled = 1'b0;
        st_data = '0;
        st_last = 1'b0;
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checks++;
                    if (!m_tvalid || m_tdata !== st_data || m_tlast !== st_last) begin
                        errors++;
                        $display("FAIL stall_hold actual valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                                 m_tvalid, m_tdata, m_tlast, st_data, st_last);
                    end
                end
                if (m_tvalid && m_tready) begin
                    checks++;
                    if (exp_res_q.size() == 0) begin
                        errors++;
                        $display("FAIL result_beat unexpected data=%h last=%b", m_tdata, m_tlast);
                    end else begin
                        r = exp_res_q.pop_front();
                        if (m_tdata !== r.data || m_tlast !== r.last) begin
                            errors++;
                            $display("FAIL result_beat actual data=%h last=%b expected data=%h last=%b",
                                     m_tdata, m_tlast, r.data, r.last);
                        end
                    end
                end
                stalled = m_tvalid && !m_tready;
                st_data = m_tdata;
                st_last = m_tlast;
            end
        end
    end

    // pe_start monitor: counts pulses and checks single-cycle width
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                prev = 1'b0;
            end else begin
                if (pe_start) begin
                    pe_start_cnt++;
                    last_start_cyc = cyc;
                    chk("pe_start_width_prev", 32'(prev), 32'd0);
                end
                prev = pe_start;
            end
        end
    end

    // PE responder: on pe_start, place results in BRAM, predict the stream, pulse pe_done
    initial begin
        res_t        r;
        logic [31:0] v;
        forever begin
            @(negedge aclk);
            #1;
            if (aresetn && pe_start && pe_mode == 1) begin
                for (int k = 0; k < VS; k++) begin
                    v          = res_fixed ? (32'hA + 32'(k)) : $urandom;
                    res_buf[k] = v;
                    r.data     = v;
                    r.last     = (k == VS - 1);
                    exp_res_q.push_back(r);
                end
                load_req++;
                repeat ($urandom_range(6, 12)) @(posedge aclk);
                #1 pe_done = 1'b1;
                @(posedge aclk);
                #1 pe_done = 1'b0;
                if (tready_mode == 0) begin
                    @(posedge aclk);
                    #1 chk("latency_cycle1_valid", 32'(m_tvalid), 32'd0);
                    for (int k = 0; k < VS; k++) begin
                        @(posedge aclk);
                        #1 chk("full_rate_valid", 32'(m_tvalid), 32'd1);
                    end
                end
            end
        end
    end

    // Drives one load. Each accepted word i is expected at byte address 4*i.
    // abort_after >= 0 asserts reset mid-cycle once that many words are accepted.
    task automatic load_stream(input bit seq, input bit gaps, input int abort_after);
        int          idx;
        int          guard;
        bit          hs;
        logic [31:0] word;
        wr_t         e;
        idx   = 0;
        guard = 0;
        word  = seq ? 32'd1 : $urandom;
        while (idx < NLOAD && guard < 1000) begin
            s_tvalid = !(gaps && ($urandom_range(0, 9) < 3));
            s_tdata  = word;
            @(negedge aclk);
            hs = s_tvalid && s_tready;
            if (hs) begin
                e.addr = 32'(idx) << 2;
                e.data = word;
                exp_wr_q.push_back(e);
            end
            @(posedge aclk);
            #1;
            guard++;
            if (hs) begin
                idx++;
                word = seq ? 32'(idx + 1) : $urandom;
            end
            if (abort_after >= 0 && idx == abort_after) begin
                s_tvalid = 1'b1;
                s_tdata  = word;
                #2 aresetn = 1'b0;
                #1 chk("reset_async_outputs", 32'(any_out()), 32'd0);
                s_tvalid = 1'b0;
                return;
            end
        end
        chk("load_bound", 32'(idx), 32'(NLOAD));
        chk("kick_pe_start", 32'(pe_start), 32'd1);
        chk("kick_busy", 32'(busy), 32'd1);
        // Keep offering data through KICK/WAIT; none of it may be consumed.
        s_tvalid = 1'b1;
        s_tdata  = 32'hDEAD_BEEF;
        repeat (3) @(posedge aclk);
        #1 s_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
        chk({name, "_wr_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
        chk({name, "_res_q_empty"}, 32'(exp_res_q.size()), 32'd0);
    endtask

    initial begin
        int exp_starts;
        int n;
        int diff;
        exp_starts = 0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1 chk("reset_outputs", 32'(any_out()), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1 chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_s_tready", 32'(s_tready), 32'd0);

        // Sequential load 1..20, results A..D with m_tready held high
        tready_mode = 0; res_fixed = 1'b1; pe_mode = 1;
        load_stream(1'b1, 1'b0, -1);
        exp_starts++;
        wait_idle("seq_load");
        chk("seq_pe_starts", 32'(pe_start_cnt), 32'(exp_starts));

        // Same with m_tready 1,0,0,1 back-pressure
        tready_mode = 1;
        load_stream(1'b1, 1'b0, -1);
        exp_starts++;
        wait_idle("pattern_ready");
        chk("pattern_pe_starts", 32'(pe_start_cnt), 32'(exp_starts));

        // Random data, random s_tvalid gaps, random back-pressure and results
        res_fixed = 1'b0; tready_mode = 2;
        for (int t = 0; t < 3; t++) begin
            load_stream(1'b0, 1'b1, -1);
            exp_starts++;
            wait_idle("random_load");
        end
        chk("random_pe_starts", 32'(pe_start_cnt), 32'(exp_starts));

        // Watchdog: pe_done never arrives
        pe_mode = 0; tready_mode = 0;
        load_stream(1'b1, 1'b0, -1);
        exp_starts++;
        n = 0;
        while (!err_timeout && n < 300) begin
            @(negedge aclk);
            n++;
        end
        chk("timeout_flag", 32'(err_timeout), 32'd1);
        diff = cyc - last_start_cyc;
        checks++;
        if (diff < 50 || diff > 51) begin
            errors++;
            $display("FAIL timeout_latency actual=%0d expected=50..51 cycles after pe_start", diff);
        end
        chk("timeout_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge aclk);
        #1 chk("timeout_sticky", 32'(err_timeout), 32'd1);

        // Next load clears the error and completes normally
        pe_mode = 1;
        load_stream(1'b1, 1'b0, -1);
        exp_starts++;
        chk("err_cleared_on_load", 32'(err_timeout), 32'd0);
        wait_idle("post_timeout");
        chk("post_timeout_pe_starts", 32'(pe_start_cnt), 32'(exp_starts));

        // Reset in the middle of a load, then a fresh load from address 0
        load_stream(1'b1, 1'b0, 10);
        repeat (2) @(posedge aclk);
        #1 chk("reset_held_outputs", 32'(any_out()), 32'd0);
        chk("abort_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        load_stream(1'b1, 1'b0, -1);
        exp_starts++;
        wait_idle("after_reset");
        chk("after_reset_pe_starts", 32'(pe_start_cnt), 32'(exp_starts));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
